// File: rtl/sram_tile_reader.sv
// Load-path tile reader: issues fixed-latency SRAM reads for incoming address beats and
// returns data with row/col tags in order through a credit-protected output FIFO.

module sram_tile_reader_chk #(
    parameter int CNT_W      = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic [CNT_W-1:0] occ,
    input  logic [CNT_W-1:0] cnt
);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    a_no_fifo_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(wr && (occ == DEPTH_C)));
    a_credit_range:     assert property (@(posedge clk) disable iff (!rst_n) (cnt <= DEPTH_C));
endmodule

module sram_tile_reader #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int SRAM_LAT   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [15:0]       in_row,
    input  logic [15:0]       in_col,
    input  logic              in_tile_done,
    output logic              sram_re,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [15:0]       out_row,
    output logic [15:0]       out_col,
    output logic              tile_complete,
    output logic              busy
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] ZERO_C     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);
    localparam logic [PTR_W-1:0] LAST_PTR_C = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR_C) ? {PTR_W{1'b0}} : (p + PTR_W'(1));
    endfunction

    state_t                       state_r;
    logic [CNT_W-1:0]             cnt_r;
    logic [CNT_W-1:0]             cnt_nxt_s;
    logic [CNT_W-1:0]             occ_r;
    logic [PTR_W-1:0]             wr_ptr_r;
    logic [PTR_W-1:0]             rd_ptr_r;
    logic [SRAM_LAT-1:0]          tag_vld_r;
    logic [SRAM_LAT-1:0][15:0]    tag_row_r;
    logic [SRAM_LAT-1:0][15:0]    tag_col_r;
    logic [DATA_W-1:0]            mem_data_r [FIFO_DEPTH];
    logic [15:0]                  mem_row_r  [FIFO_DEPTH];
    logic [15:0]                  mem_col_r  [FIFO_DEPTH];
    logic                         done_pend_s;
    logic                         accept_s;
    logic                         pop_s;
    logic                         wr_s;

    assign done_pend_s   = (state_r == ST_DRAIN) || (state_r == ST_DONE);
    assign in_ready      = (cnt_r < DEPTH_C) && !done_pend_s;
    assign accept_s      = in_valid && in_ready;
    assign sram_re       = accept_s;
    assign sram_addr     = in_addr;
    assign out_valid     = (occ_r != ZERO_C);
    assign pop_s         = out_valid && out_ready;
    assign wr_s          = tag_vld_r[SRAM_LAT-1];
    assign tile_complete = (state_r == ST_DONE);
    assign busy          = (cnt_r != ZERO_C) || (state_r != ST_IDLE);

    // Head is masked while empty so stale entries never appear on out_*.
    assign out_data = out_valid ? mem_data_r[rd_ptr_r] : {DATA_W{1'b0}};
    assign out_row  = out_valid ? mem_row_r[rd_ptr_r]  : 16'h0000;
    assign out_col  = out_valid ? mem_col_r[rd_ptr_r]  : 16'h0000;

    // Next credit count: reads in flight plus FIFO occupancy.
    always_comb begin
        cnt_nxt_s = cnt_r;
        case ({accept_s, pop_s})
            2'b10:   cnt_nxt_s = cnt_r + ONE_C;
            2'b01:   cnt_nxt_s = cnt_r - ONE_C;
            default: cnt_nxt_s = cnt_r;
        endcase
    end

    // Credit counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= ZERO_C;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    // Tag pipe tracks each issued read until its data returns from SRAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_r <= {SRAM_LAT{1'b0}};
            tag_row_r <= {(SRAM_LAT*16){1'b0}};
            tag_col_r <= {(SRAM_LAT*16){1'b0}};
        end else begin
            tag_vld_r[0] <= accept_s;
            tag_row_r[0] <= in_row;
            tag_col_r[0] <= in_col;
            for (int i = 1; i < SRAM_LAT; i++) begin
                tag_vld_r[i] <= tag_vld_r[i-1];
                tag_row_r[i] <= tag_row_r[i-1];
                tag_col_r[i] <= tag_col_r[i-1];
            end
        end
    end

    // FIFO storage; only written when the matching read data lands.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_data_r[wr_ptr_r] <= sram_rdata;
            mem_row_r[wr_ptr_r]  <= tag_row_r[SRAM_LAT-1];
            mem_col_r[wr_ptr_r]  <= tag_col_r[SRAM_LAT-1];
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            occ_r    <= ZERO_C;
        end else begin
            if (wr_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({wr_s, pop_s})
                2'b10:   occ_r <= occ_r + ONE_C;
                2'b01:   occ_r <= occ_r - ONE_C;
                default: occ_r <= occ_r;
            endcase
        end
    end

    // Tile tracking; DRAIN looks at the next credit count so completion follows the final pop directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_tile_done) begin
                        state_r <= ST_DRAIN;
                    end else if (accept_s) begin
                        state_r <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (in_tile_done) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_nxt_s == ZERO_C) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: state_r <= ST_IDLE;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    sram_tile_reader_chk #(
        .CNT_W      (CNT_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (wr_s),
        .occ   (occ_r),
        .cnt   (cnt_r)
    );
endmodule

// File: tb/tb_sram_tile_reader.sv
// Directed bench for sram_tile_reader: scoreboard of issued beats checked against FIFO pops.

module tb_sram_tile_reader;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_addr;
    logic [15:0] in_row;
    logic [15:0] in_col;
    logic        in_tile_done;
    logic        sram_re;
    logic [15:0] sram_addr;
    logic [31:0] sram_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [15:0] out_row;
    logic [15:0] out_col;
    logic        tile_complete;
    logic        busy;

    sram_tile_reader #(
        .ADDR_W     (16),
        .DATA_W     (32),
        .SRAM_LAT   (LAT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_addr       (in_addr),
        .in_row        (in_row),
        .in_col        (in_col),
        .in_tile_done  (in_tile_done),
        .sram_re       (sram_re),
        .sram_addr     (sram_addr),
        .sram_rdata    (sram_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_row       (out_row),
        .out_col       (out_col),
        .tile_complete (tile_complete),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [15:0] a);
        if (a == 16'h0010) return 32'hDEADBEEF;
        return {a ^ 16'h5A5A, ~a};
    endfunction

    // SRAM model: data valid exactly LAT cycles after sram_re.
    logic [LAT-1:0]       re_pipe;
    logic [LAT-1:0][15:0] addr_pipe;
    always @(posedge clk) begin
        re_pipe   <= {re_pipe[LAT-2:0], sram_re};
        addr_pipe <= {addr_pipe[LAT-2:0], sram_addr};
    end
    assign sram_rdata = re_pipe[LAT-1] ? mem_f(addr_pipe[LAT-1]) : 32'hBADBAD00;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb[$];
    int          k, n_beats, ncols, mode, cyc;
    logic [15:0] base;
    bit          done_now, done_at_last;
    int          n_pop, pop_first, pop_last, acc_first, acc_last, tc_cnt;
    int          tc0, pop0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at the falling edge, sample 1 time unit later, then wait for the next falling edge.
    task automatic tick();
        logic acc;
        in_valid     = (k < n_beats);
        in_addr      = base + 16'(k);
        in_row       = 16'(k / ncols);
        in_col       = 16'(k % ncols);
        in_tile_done = done_now || (done_at_last && (k == n_beats - 1));
        out_ready    = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(1, 0)) : 1'b0;
        #1;
        acc = in_valid && in_ready;
        if (sb.size() >= DEPTH) check("credit_full", {63'd0, in_ready}, 64'd0);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) check("unexpected_pop", 64'd1, 64'd0);
            else check("beat", {out_data, out_row, out_col}, sb.pop_front());
            if (pop_first < 0) pop_first = cyc;
            pop_last = cyc;
            n_pop++;
        end
        if (acc) begin
            check("sram_re", {63'd0, sram_re}, 64'd1);
            check("sram_addr", {48'd0, sram_addr}, {48'd0, in_addr});
            sb.push_back({mem_f(in_addr), in_row, in_col});
            if (acc_first < 0) acc_first = cyc;
            acc_last = cyc;
            k++;
        end
        if (tile_complete) tc_cnt++;
        cyc++;
        @(negedge clk);
    endtask

    task automatic start_stream(input int n, input logic [15:0] b, input int nc, input int m);
        k = 0; n_beats = n; base = b; ncols = nc; mode = m;
        pop_first = -1; acc_first = -1; pop0 = n_pop; tc0 = tc_cnt;
    endtask

    task automatic finish_tile(input string tag);
        int t0;
        t0 = tc_cnt;
        mode = 0;
        done_now = 1'b1;
        tick();
        done_now = 1'b0;
        for (int i = 0; i < 20 && tc_cnt == t0; i++) tick();
        tick();
        tick();
        check({tag, "_tc"}, 64'(tc_cnt - t0), 64'd1);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_sb"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_addr = 16'h1234; in_row = 16'h0; in_col = 16'h0;
        in_tile_done = 1'b0; out_ready = 1'b0;
        k = 0; n_beats = 0; ncols = 1; mode = 2; cyc = 0; base = 16'h0;
        done_now = 1'b0; done_at_last = 1'b0;
        n_pop = 0; pop_first = -1; pop_last = 0; acc_first = -1; acc_last = 0; tc_cnt = 0;
        #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_sram_re", {63'd0, sram_re}, 64'd0);
        check("rst_sram_addr", {48'd0, sram_addr}, 64'h1234);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_head", {out_data, out_row, out_col}, 64'd0);
        check("rst_tc", {63'd0, tile_complete}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single beat: out_valid exactly LAT+1 cycles after the accept.
        start_stream(1, 16'h0010, 1, 2);
        tick();
        check("t1_valid_t1", {63'd0, out_valid}, 64'd0);
        tick();
        check("t1_valid_t2", {63'd0, out_valid}, 64'd0);
        tick();
        check("t1_valid_t3", {63'd0, out_valid}, 64'd1);
        check("t1_data", {32'd0, out_data}, 64'hDEADBEEF);
        check("t1_tags", {32'd0, out_row, out_col}, 64'd0);
        check("t1_busy", {63'd0, busy}, 64'd1);
        done_now = 1'b1;
        tick();
        done_now = 1'b0;
        check("t1_tc_before_pop", {63'd0, tile_complete}, 64'd0);
        mode = 0;
        tick();
        check("t1_tc_after_pop", {63'd0, tile_complete}, 64'd1);
        tick();
        check("t1_tc_one_cycle", {63'd0, tile_complete}, 64'd0);
        check("t1_busy_end", {63'd0, busy}, 64'd0);

        // 4x4 tile at full rate, tile_done coincident with the last accept.
        start_stream(16, 16'h0100, 4, 0);
        done_at_last = 1'b1;
        for (int i = 0; i < 60 && !(k == 16 && sb.size() == 0 && tc_cnt != tc0); i++) tick();
        done_at_last = 1'b0;
        tick();
        tick();
        check("t2_accepts", 64'(k), 64'd16);
        check("t2_pops", 64'(n_pop - pop0), 64'd16);
        check("t2_acc_b2b", 64'(acc_last - acc_first), 64'd15);
        check("t2_pop_b2b", 64'(pop_last - pop_first), 64'd15);
        check("t2_latency", 64'(pop_first - acc_first), 64'(LAT + 1));
        check("t2_tc_once", 64'(tc_cnt - tc0), 64'd1);

        // Consumer stalled: exactly DEPTH accepts, head held, then release.
        start_stream(16, 16'h0300, 4, 2);
        for (int i = 0; i < 7; i++) tick();
        check("t3_head_c7", {out_data, out_row, out_col}, {mem_f(16'h0300), 32'd0});
        for (int i = 0; i < 3; i++) tick();
        check("t3_accepts", 64'(k), 64'd4);
        check("t3_in_ready", {63'd0, in_ready}, 64'd0);
        check("t3_head_c10", {out_data, out_row, out_col}, {mem_f(16'h0300), 32'd0});
        mode = 0;
        for (int i = 0; i < 100 && !(k == 16 && sb.size() == 0); i++) tick();
        check("t3_accepts_all", 64'(k), 64'd16);
        check("t3_pops", 64'(n_pop - pop0), 64'd16);
        finish_tile("t3");

        // Random consumer backpressure over 64 beats.
        start_stream(64, 16'h2000, 8, 1);
        for (int i = 0; i < 1000 && !(k == 64 && sb.size() == 0); i++) tick();
        check("t4_accepts", 64'(k), 64'd64);
        check("t4_pops", 64'(n_pop - pop0), 64'd64);
        finish_tile("t4");

        // Zero-size tile: complete pulses two cycles after tile_done.
        start_stream(0, 16'h0000, 1, 0);
        check("t5_busy_pre", {63'd0, busy}, 64'd0);
        done_now = 1'b1;
        tick();
        done_now = 1'b0;
        check("t5_busy_c1", {63'd0, busy}, 64'd1);
        check("t5_tc_c1", {63'd0, tile_complete}, 64'd0);
        tick();
        check("t5_busy_c2", {63'd0, busy}, 64'd1);
        check("t5_tc_c2", {63'd0, tile_complete}, 64'd1);
        tick();
        check("t5_busy_c3", {63'd0, busy}, 64'd0);
        check("t5_tc_c3", {63'd0, tile_complete}, 64'd0);

        // Reset with reads in flight, then a fresh tile.
        start_stream(3, 16'h0500, 1, 2);
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t6_in_ready", {63'd0, in_ready}, 64'd1);
        check("t6_sram_re", {63'd0, sram_re}, 64'd0);
        check("t6_out_valid", {63'd0, out_valid}, 64'd0);
        check("t6_out_head", {out_data, out_row, out_col}, 64'd0);
        check("t6_busy", {63'd0, busy}, 64'd0);
        check("t6_tc", {63'd0, tile_complete}, 64'd0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        start_stream(4, 16'h0600, 2, 0);
        for (int i = 0; i < 30 && !(k == 4 && sb.size() == 0); i++) tick();
        check("t6_no_tc", 64'(tc_cnt - tc0), 64'd0);
        check("t6_pops", 64'(n_pop - pop0), 64'd4);
        finish_tile("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_tile_reader.md
# sram_tile_reader

Downstream consumer of the tile address generator in the load path. Accepts one (addr, row, col) beat per cycle over valid/ready, issues a fixed-latency SRAM read for each, and returns the read data with its row/col tags in order through a small output FIFO. Credit-based flow control ensures no read is issued without a guaranteed FIFO slot. After the generator's end-of-tile pulse, the block signals tile completion once every issued read has drained to the consumer.

## Interface
- ADDR_W, 16, SRAM address width
- DATA_W, 32, SRAM read-data width
- SRAM_LAT, 2, fixed SRAM read latency in cycles (≥1)
- FIFO_DEPTH, 4, output FIFO entries (power of 2, ≥ SRAM_LAT+2 for full throughput)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  address beat valid (from generator addr_valid)
- in_ready  out  1  beat accepted when in_valid && in_ready (drives generator addr_ready)
- in_addr  in  ADDR_W  SRAM read address
- in_row  in  16  row tag
- in_col  in  16  column tag
- in_tile_done  in  1  single-cycle end-of-tile pulse from generator
- sram_re  out  1  read enable
- sram_addr  out  ADDR_W  read address
- sram_rdata  in  DATA_W  read data, valid exactly SRAM_LAT cycles after sram_re
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer pop
- out_data  out  DATA_W  head data
- out_row  out  16  head row tag
- out_col  out  16  head column tag
- tile_complete  out  1  single-cycle pulse: tile fully drained
- busy  out  1  reads in flight, FIFO non-empty, or done pending

## Operation
- credit count `cnt` (0..FIFO_DEPTH) = in-flight reads + FIFO occupancy; +1 on accept, −1 on pop (out_valid && out_ready); both in the same cycle → unchanged.
- in_ready = (cnt < FIFO_DEPTH) && !done_pend; registered-state function only, no combinational path from out_ready.
- accept: sram_re = in_valid && in_ready; sram_addr = in_addr (combinational pass-through). Row/col tags enter a SRAM_LAT-deep tag shift register alongside a valid bit.
- return: when the tag pipe's last stage is valid, {sram_rdata, row, col} is written into the FIFO at that clock edge. Overflow is impossible by construction; an assertion checks write-when-full never occurs.
- FIFO: circular buffer with wrap-around read/write pointers and an occupancy counter; out_* driven from head; pop on out_valid && out_ready. Ordering is strictly in issue order.
- tile tracking FSM:
  - IDLE → ACTIVE on the first accept.
  - ACTIVE → DRAIN on in_tile_done; done_pend=1.
  - DRAIN → DONE when cnt==0.
  - DONE → IDLE after one cycle; tile_complete=1 in DONE.
  - in_tile_done in IDLE (zero-size tile) → DRAIN directly, so tile_complete still pulses.
- busy = (cnt != 0) || (state != IDLE).

## Timing
- reset values: in_ready=1, sram_re=0, sram_addr=in_addr, out_valid=0, out_data/out_row/out_col=0, tile_complete=0, busy=0; pointers, cnt, tag pipe and FSM cleared.
- accept in cycle t → out_valid high in cycle t+SRAM_LAT+1 (FIFO empty case).
- sustained 1 beat/cycle when out_ready held high and FIFO_DEPTH ≥ SRAM_LAT+2.
- out_ready low: out_* held stable; in_ready drops once cnt reaches FIFO_DEPTH; in-flight reads still land.
- tile_complete asserts the cycle after the final pop brings cnt to 0 (DRAIN→DONE edge).
- in_tile_done coincident with the final accept: both take effect; done waits for that read to drain.
- reset mid-tile: in-flight reads and FIFO contents are discarded; no tile_complete is emitted.

## Test plan
- single beat: addr=0x0010, row=0, col=0, sram returns 0xDEADBEEF → out_valid at t+3, out_data=0xDEADBEEF, row/col=0; tile_done → tile_complete one cycle after the pop.
- 4×4 tile streamed with out_ready=1 → 16 outputs in order, back-to-back with no bubbles, tags (0,0)..(3,3), exactly one tile_complete.
- out_ready=0 during a 16-beat stream → exactly 4 accepts, then in_ready=0; release → remaining 12 accepted, no loss or duplication.
- random out_ready (50%) over 64 beats → data/tags match a scoreboard; cnt never exceeds 4; no FIFO overflow assertion fires.
- zero-size tile (in_tile_done with no beats) → tile_complete pulses 2 cycles later; busy high for those 2 cycles only.
- rst_n asserted with 3 reads in flight → all outputs return to reset values immediately; after release, a new tile streams correctly.
